// File: rtl/nn_seq.sv
// Frame sequencer for a pixel-buffer inference core: loads one frame from a
// byte stream, starts the core, waits for completion or timeout, and hands off the result.
module nn_seq #(
  parameter int N_IN    = 784,
  parameter int TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        nn_pix_we,
  output logic [9:0]  nn_pix_addr,
  output logic [7:0]  nn_pix_data,
  output logic        nn_start,
  input  logic        nn_done,
  input  logic [3:0]  nn_predicted,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [3:0]  res_class,
  output logic        res_timeout,
  output logic [31:0] res_cycles,
  output logic        busy,
  output logic        err_len
);

  typedef enum logic [2:0] {
    LOAD,
    DRAIN,
    START,
    WAIT_DONE,
    RELEASE,
    RESULT
  } state_t;

  localparam logic [9:0]  LAST_IDX    = 10'(N_IN - 1);
  localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT);

  state_t      state_q, state_d;
  logic [9:0]  count_q, count_d;
  logic [31:0] cyc_q, cyc_d;
  logic        ready_en_q;

  logic        we_d;
  logic [9:0]  addr_d;
  logic [7:0]  data_d;
  logic        start_d;
  logic        valid_d;
  logic [3:0]  class_d;
  logic        timeout_d;
  logic [31:0] cycles_d;
  logic        err_d;
  logic        beat;

  // The stream is only offered once the first clock edge after reset has passed.
  assign s_ready = ready_en_q && (state_q == LOAD || state_q == DRAIN);
  assign beat    = s_valid && s_ready;
  assign busy    = !(state_q == LOAD && count_q == '0);

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cyc_d     = cyc_q;
    we_d      = 1'b0;
    addr_d    = nn_pix_addr;
    data_d    = nn_pix_data;
    err_d     = 1'b0;
    start_d   = 1'b0;
    valid_d   = res_valid;
    class_d   = res_class;
    timeout_d = res_timeout;
    cycles_d  = res_cycles;

    case (state_q)
      LOAD: begin
        if (beat) begin
          we_d   = 1'b1;
          addr_d = count_q;
          data_d = s_data;
          if (count_q == LAST_IDX) begin
            count_d = '0;
            if (s_last) begin
              state_d = START;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (s_last) begin
            // Short frame: written but never inferred on.
            count_d = '0;
            err_d   = 1'b1;
          end else begin
            count_d = count_q + 10'd1;
          end
        end
      end

      DRAIN: begin
        if (beat && s_last) state_d = LOAD;
      end

      START: begin
        start_d = 1'b1;
        cyc_d   = 32'd1;
        state_d = WAIT_DONE;
      end

      WAIT_DONE: begin
        start_d = 1'b1;
        if (nn_done) begin
          class_d   = nn_predicted;
          timeout_d = 1'b0;
          cycles_d  = cyc_q;
          start_d   = 1'b0;
          state_d   = RELEASE;
        end else if (cyc_q >= TIMEOUT_CYC) begin
          class_d   = 4'hF;
          timeout_d = 1'b1;
          cycles_d  = TIMEOUT_CYC;
          start_d   = 1'b0;
          state_d   = RELEASE;
        end else if (cyc_q != '1) begin
          cyc_d = cyc_q + 32'd1;
        end
      end

      RELEASE: begin
        // Wait for the core to drop done so the next start is seen as fresh.
        if (!nn_done) begin
          valid_d = 1'b1;
          state_d = RESULT;
        end
      end

      RESULT: begin
        if (res_ready) begin
          valid_d = 1'b0;
          state_d = LOAD;
        end
      end

      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      count_q     <= '0;
      cyc_q       <= '0;
      ready_en_q  <= 1'b0;
      nn_pix_we   <= 1'b0;
      nn_pix_addr <= '0;
      nn_pix_data <= '0;
      nn_start    <= 1'b0;
      res_valid   <= 1'b0;
      res_class   <= '0;
      res_timeout <= 1'b0;
      res_cycles  <= '0;
      err_len     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cyc_q       <= cyc_d;
      ready_en_q  <= 1'b1;
      nn_pix_we   <= we_d;
      nn_pix_addr <= addr_d;
      nn_pix_data <= data_d;
      nn_start    <= start_d;
      res_valid   <= valid_d;
      res_class   <= class_d;
      res_timeout <= timeout_d;
      res_cycles  <= cycles_d;
      err_len     <= err_d;
    end
  end

endmodule

// File: tb/tb_nn_seq.sv
// Directed bench for nn_seq: table of frame scenarios plus hand-written
// sequences for reset, result backpressure, reset during inference and timeout.
module tb_nn_seq;

  logic        clk;
  logic        rst_n;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_data;
  logic        nn_pix_we;
  logic [9:0]  nn_pix_addr;
  logic [7:0]  nn_pix_data;
  logic        nn_start, nn_done;
  logic [3:0]  nn_predicted;
  logic        res_valid, res_ready, res_timeout;
  logic [3:0]  res_class;
  logic [31:0] res_cycles;
  logic        busy, err_len;

  logic        t_valid, t_ready, t_last;
  logic [7:0]  t_data;
  logic        t_we;
  logic [9:0]  t_addr;
  logic [7:0]  t_pdata;
  logic        t_start, t_done;
  logic [3:0]  t_pred;
  logic        t_rvalid, t_rready, t_to;
  logic [3:0]  t_class;
  logic [31:0] t_cycles;
  logic        t_busy, t_err;

  int checks = 0;
  int errors = 0;

  nn_seq #(.N_IN(784), .TIMEOUT(65536)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .nn_pix_we(nn_pix_we), .nn_pix_addr(nn_pix_addr), .nn_pix_data(nn_pix_data),
    .nn_start(nn_start), .nn_done(nn_done), .nn_predicted(nn_predicted),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .res_timeout(res_timeout), .res_cycles(res_cycles),
    .busy(busy), .err_len(err_len)
  );

  nn_seq #(.N_IN(16), .TIMEOUT(100)) u_to (
    .clk(clk), .rst_n(rst_n),
    .s_valid(t_valid), .s_ready(t_ready), .s_data(t_data), .s_last(t_last),
    .nn_pix_we(t_we), .nn_pix_addr(t_addr), .nn_pix_data(t_pdata),
    .nn_start(t_start), .nn_done(t_done), .nn_predicted(t_pred),
    .res_valid(t_rvalid), .res_ready(t_rready), .res_class(t_class),
    .res_timeout(t_to), .res_cycles(t_cycles),
    .busy(t_busy), .err_len(t_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  // Core models: done rises once start has been high for the programmed number of cycles.
  int core_dly = 1;
  int core_cnt = 0;
  always @(negedge clk) begin
    if (!nn_start) begin
      core_cnt = 0;
      nn_done  = 1'b0;
    end else begin
      core_cnt++;
      if (core_cnt >= core_dly) nn_done = 1'b1;
    end
  end

  int t_dly = 0;
  int t_cnt = 0;
  int t_hi_total = 0;
  always @(negedge clk) begin
    if (!t_start) begin
      t_cnt  = 0;
      t_done = 1'b0;
    end else begin
      t_cnt++;
      t_hi_total++;
      if (t_dly != 0 && t_cnt >= t_dly) t_done = 1'b1;
    end
  end

  // Monitor: logs writes, error pulses and start rises with cycle stamps.
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [17:0] wr_log [8192];
  int   wr_total = 0, last_we = 0;
  int   err_total = 0, err_addr = 0;
  logic err_we = 1'b0;
  int   start_total = 0, start_rise = 0;
  logic start_prev = 1'b0;
  always @(negedge clk) begin
    if (nn_pix_we) begin
      if (wr_total < 8192) wr_log[wr_total] = {nn_pix_addr, nn_pix_data};
      wr_total++;
      last_we = cyc;
    end
    if (err_len) begin
      err_total++;
      err_addr = int'(nn_pix_addr);
      err_we   = nn_pix_we;
    end
    if (nn_start && !start_prev) begin
      start_total++;
      start_rise = cyc;
    end
    start_prev = nn_start;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int w;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    w = 0;
    while (!s_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) check("beat_accept", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input int seed);
    for (int i = 0; i < n; i++) send_beat(8'(i + seed), i == n - 1);
  endtask

  task automatic wait_result(input string tag, output logic [3:0] c, output logic t,
                             output logic [31:0] cy);
    int w;
    w = 0;
    @(negedge clk);
    while (!res_valid && w < 70000) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    c  = res_class;
    t  = res_timeout;
    cy = res_cycles;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_res_drop"}, 32'(res_valid), 32'd0);
    res_ready = 1'b0;
  endtask

  typedef struct {
    int         n_beats;
    logic [3:0] cls;
    int         dly;
    int         exp_writes;
    int         exp_errs;
    int         exp_err_addr;
    bit         exp_start;
  } frame_vec_t;

  task automatic run_frame(input frame_vec_t v, input int idx);
    int          wb, eb, sb, bad, seed;
    logic [3:0]  c;
    logic        t;
    logic [31:0] cy;
    string       tag;
    tag  = $sformatf("v%0d", idx);
    seed = idx * 37;
    nn_predicted = v.cls;
    core_dly     = v.dly;
    wb = wr_total;
    eb = err_total;
    sb = start_total;
    send_frame(v.n_beats, seed);
    if (v.exp_start) begin
      wait_result(tag, c, t, cy);
      check({tag, "_start_lag"}, 32'(start_rise - last_we), 32'd1);
      check({tag, "_class"}, 32'(c), 32'(v.cls));
      check({tag, "_timeout"}, 32'(t), 32'd0);
      check({tag, "_cycles"}, cy, 32'(v.dly));
    end else begin
      repeat (5) @(negedge clk);
      check({tag, "_no_result"}, 32'(res_valid), 32'd0);
    end
    check({tag, "_writes"}, 32'(wr_total - wb), 32'(v.exp_writes));
    bad = 0;
    for (int i = wb; i < wr_total && i < 8192; i++)
      if (wr_log[i] !== {10'(i - wb), 8'(i - wb + seed)}) bad++;
    check({tag, "_wr_addr_data"}, 32'(bad), 32'd0);
    check({tag, "_err_count"}, 32'(err_total - eb), 32'(v.exp_errs));
    if (v.exp_errs > 0) begin
      check({tag, "_err_addr"}, 32'(err_addr), 32'(v.exp_err_addr));
      check({tag, "_err_with_we"}, 32'(err_we), 32'd1);
    end
    check({tag, "_starts"}, 32'(start_total - sb), 32'(v.exp_start));
    repeat (2) @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_ready"}, 32'(s_ready), 32'd1);
  endtask

  task automatic t_send_frame();
    int w;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      t_valid = 1'b1;
      t_data  = 8'(i);
      t_last  = (i == 15);
      w = 0;
      while (!t_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      @(posedge clk);
      #1 t_valid = 1'b0;
    end
  endtask

  task automatic t_run(input string tag, input int dly, input logic [3:0] pred,
                       input logic [3:0] exp_c, input logic exp_t);
    int hb, w;
    t_dly  = dly;
    t_pred = pred;
    hb = t_hi_total;
    t_send_frame();
    w = 0;
    @(negedge clk);
    while (!t_rvalid && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_res_valid"}, 32'(t_rvalid), 32'd1);
    check({tag, "_class"}, 32'(t_class), 32'(exp_c));
    check({tag, "_timeout"}, 32'(t_to), 32'(exp_t));
    check({tag, "_cycles"}, t_cycles, 32'd100);
    check({tag, "_start_high"}, 32'(t_hi_total - hb), 32'd100);
    t_rready = 1'b1;
    @(posedge clk);
    #1 t_rready = 1'b0;
  endtask

  frame_vec_t vecs [6];

  initial begin
    logic [3:0]  c0;
    logic [31:0] cy0;
    logic        to0;
    int          bad, w;
    frame_vec_t  rv;

    vecs[0] = '{784, 4'd7,  25000, 784, 0, 0,   1'b1};
    vecs[1] = '{100, 4'd0,  0,     100, 1, 99,  1'b0};
    vecs[2] = '{784, 4'd3,  40,    784, 0, 0,   1'b1};
    vecs[3] = '{800, 4'd0,  0,     784, 1, 783, 1'b0};
    vecs[4] = '{1,   4'd0,  0,     1,   1, 0,   1'b0};
    vecs[5] = '{784, 4'd12, 1,     784, 0, 0,   1'b1};

    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    res_ready = 1'b0; nn_predicted = '0;
    t_valid = 1'b0; t_data = '0; t_last = 1'b0;
    t_rready = 1'b0; t_pred = '0;

    #12;
    check("rst_start", 32'(nn_start), 32'd0);
    check("rst_we", 32'(nn_pix_we), 32'd0);
    check("rst_addr_data", 32'({nn_pix_addr, nn_pix_data}), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_fields", 32'({res_class, res_timeout}), 32'd0);
    check("rst_res_cycles", res_cycles, 32'd0);
    check("rst_err", 32'(err_len), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready_low", 32'(s_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(s_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

    // Result held back by the consumer for 50 cycles.
    nn_predicted = 4'd5;
    core_dly     = 10;
    send_frame(784, 11);
    w = 0;
    @(negedge clk);
    while (!res_valid && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("bp_res_valid", 32'(res_valid), 32'd1);
    c0 = res_class; to0 = res_timeout; cy0 = res_cycles;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!res_valid || res_class !== c0 || res_timeout !== to0 || res_cycles !== cy0 ||
          s_ready || nn_pix_we)
        bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    check("bp_class", 32'(c0), 32'd5);
    check("bp_cycles", cy0, 32'd10);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_accept", 32'(res_valid), 32'd0);
    res_ready = 1'b0;

    // Reset while the core is running.
    nn_predicted = 4'd2;
    core_dly     = 5000;
    send_frame(784, 3);
    w = 0;
    while (!nn_start && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("mid_start_seen", 32'(nn_start), 32'd1);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_start", 32'(nn_start), 32'd0);
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rv = '{784, 4'd9, 30, 784, 0, 0, 1'b1};
    run_frame(rv, 9);

    t_run("to_expire", 0, 4'd6, 4'hF, 1'b1);
    t_run("to_done_wins", 100, 4'd6, 4'd6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_seq.md
NN_SEQ -- requirements
Module: nn_seq

Interface
REQ-001 Parameter N_IN, default 784, SHALL be the pixels per frame (1..1024).
REQ-002 Parameter TIMEOUT, default 65536, SHALL be the maximum cycles allowed in WAIT_DONE.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 s_valid / s_ready / s_data / s_last  in / out / in[8] / in  SHALL form the pixel stream (uint8, one pixel per beat, s_last on the final beat).
REQ-006 nn_pix_we / nn_pix_addr / nn_pix_data  out / out[10] / out[8]  SHALL be the pixel-buffer write port of the inference core.
REQ-007 nn_start  out  1  SHALL be the level start to the core.
REQ-008 nn_done / nn_predicted  in / in[4]  SHALL be the core's completion level and class.
REQ-009 res_valid / res_ready / res_class / res_timeout / res_cycles  out / in / out[4] / out / out[32]  SHALL form the result handshake.
REQ-010 busy  out  1  SHALL be high in every state except LOAD with count==0.
REQ-011 err_len  out  1  SHALL be a one-cycle pulse on a frame-length error.

Function
REQ-012 States SHALL be LOAD, DRAIN, START, WAIT_DONE, RELEASE, RESULT.
REQ-013 s_ready SHALL be 1 only in LOAD and DRAIN; a beat is accepted when s_valid&&s_ready.
REQ-014 LOAD: each accepted beat SHALL drive nn_pix_we=1, nn_pix_addr=count, nn_pix_data=s_data on the next cycle (registered, latency 1), then count++.
REQ-015 LOAD: accepted beat with s_last and count==N_IN-1 SHALL write it, clear count, and go to START.
REQ-016 LOAD: accepted beat with s_last and count<N_IN-1 SHALL write it, pulse err_len, clear count, stay in LOAD (short frame discarded, no inference).
REQ-017 LOAD: accepted beat without s_last at count==N_IN-1 SHALL write it, pulse err_len, clear count, go to DRAIN.
REQ-018 DRAIN: accepted beats SHALL NOT write; beat with s_last SHALL return to LOAD.
REQ-019 START: nn_start SHALL go 1 (registered; first cycle high is exactly one cycle after the final nn_pix_we cycle), cycle counter cleared to 1, go to WAIT_DONE.
REQ-020 WAIT_DONE: nn_start held 1; counter increments each cycle, saturating at 0xFFFFFFFF.
REQ-021 WAIT_DONE: nn_done==1 SHALL latch res_class=nn_predicted, res_timeout=0, res_cycles=counter, drive nn_start=0, go to RELEASE.
REQ-022 WAIT_DONE: counter reaching TIMEOUT without nn_done SHALL latch res_class=4'hF, res_timeout=1, res_cycles=TIMEOUT, drive nn_start=0, go to RELEASE; nn_done in the same cycle SHALL take priority (normal completion).
REQ-023 RELEASE: nn_start SHALL stay 0; go to RESULT once nn_done==0 is sampled.
REQ-024 RESULT: res_valid=1 with res_class/res_timeout/res_cycles stable until res_valid&&res_ready, then res_valid=0, go to LOAD.
REQ-025 nn_pix_we SHALL be 0 except per REQ-014/015/016/017; nn_start SHALL be 0 outside START/WAIT_DONE.
REQ-026 s_data/s_last SHALL be ignored when s_valid==0; res_ready SHALL be ignored outside RESULT.

Reset
REQ-027 rst_n low SHALL immediately force state LOAD, count 0, counter 0, nn_pix_we 0, nn_pix_addr 0, nn_pix_data 0, nn_start 0, res_valid 0, res_class 0, res_timeout 0, res_cycles 0, err_len 0; s_ready SHALL be 1 from the first clock edge after rst_n rises.
REQ-028 Reset mid-frame or mid-inference SHALL discard the partial frame and result; the next frame SHALL restart at address 0.

Verification
REQ-029 N_IN=784 frame of pixels p[i]=i&0xFF, s_last on beat 783, core model returns class 7 after 25000 cycles -> 784 writes addr 0..783 with matching data, nn_start rises 1 cycle after write 783, res_valid with res_class=7, res_timeout=0, res_cycles=25000.
REQ-030 Frame with s_last on beat 99 -> err_len pulses once, 100 writes, nn_start stays 0, next full frame writes from addr 0 and completes normally.
REQ-031 Frame of 800 beats, s_last on beat 799 -> 784 writes, err_len pulse at beat 783, beats 784..799 accepted without writes, no nn_start, state LOAD afterwards.
REQ-032 TIMEOUT=100, core never raises nn_done -> nn_start falls after 100 cycles, res_class=4'hF, res_timeout=1, res_cycles=100.
REQ-033 res_ready held 0 for 50 cycles in RESULT -> res_valid and result fields stable, s_ready 0, nn_pix_we 0 throughout; acceptance on first res_ready=1 cycle.
REQ-034 rst_n asserted during WAIT_DONE -> nn_start 0 asynchronously, res_valid 0; after release a full frame completes with correct class.
